// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the ALU + register-file Processor: queues commands,
// runs each as write-pulse then read-back, and hands the result downstream.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [2:0]       in_rd,
  output logic [1:0]       p_opcode,
  output logic [7:0]       p_a,
  output logic [7:0]       p_b,
  output logic [2:0]       p_write_reg,
  output logic             p_write_enable,
  output logic [2:0]       p_read_reg,
  input  logic [7:0]       p_read_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_reg,
  output logic             busy,
  output logic [CNT_W-1:0] fill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, capture, release_res;

  logic [1:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_rd;

  // Both interfaces: a transfer happens on a rising edge where valid and ready
  // are both high; valid holds its payload until then, ready never waits on valid.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    next_state     = state;
    pop            = 1'b0;
    p_write_enable = 1'b0;
    capture        = 1'b0;
    release_res    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        p_write_enable = 1'b1;
        next_state     = READ;
      end
      READ: begin
        capture    = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          release_res = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Storage is not reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_opcode, in_a, in_b, in_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_op <= '0;
      cmd_a  <= '0;
      cmd_b  <= '0;
      cmd_rd <= '0;
    end else if (pop) begin
      {cmd_op, cmd_a, cmd_b, cmd_rd} <= mem[rd_ptr];
    end
  end

  // Result is captured one cycle after the write so it reflects the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_reg   <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= p_read_data;
      res_reg   <= cmd_rd;
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

  assign p_opcode    = cmd_op;
  assign p_a         = cmd_a;
  assign p_b         = cmd_b;
  assign p_write_reg = cmd_rd;
  assign p_read_reg  = cmd_rd;
  assign busy        = (state != IDLE);
  assign fill_count  = count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU + 8x8 register file.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_opcode;
  logic [7:0]       in_a, in_b;
  logic [2:0]       in_rd;
  logic [1:0]       p_opcode;
  logic [7:0]       p_a, p_b;
  logic [2:0]       p_write_reg;
  logic             p_write_enable;
  logic [2:0]       p_read_reg;
  logic [7:0]       p_read_data;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [2:0]       res_reg;
  logic             busy;
  logic [CNT_W-1:0] fill_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_count = 0;
  int hs_count = 0;
  logic [10:0] exp_q[$];
  int          hs_q[$];
  logic [10:0] exp_e;
  logic [40:0] outs;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .p_opcode(p_opcode), .p_a(p_a), .p_b(p_b),
    .p_write_reg(p_write_reg), .p_write_enable(p_write_enable),
    .p_read_reg(p_read_reg), .p_read_data(p_read_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_reg(res_reg),
    .busy(busy), .fill_count(fill_count)
  );

  // Processor model: ALU result written at the edge, combinational read port.
  logic [7:0] rf [8];

  function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  always @(posedge clk) begin
    if (p_write_enable) rf[p_write_reg] <= alu(p_opcode, p_a, p_b);
  end
  assign p_read_data = rf[p_read_reg];

  assign outs = {p_opcode, p_a, p_b, p_write_reg, p_read_reg, p_write_enable,
                 res_valid, res_data, res_reg, busy, fill_count};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (p_write_enable) we_count = we_count + 1;
    if (!rst && res_valid && res_ready) begin
      hs_q.push_back(cyc);
      hs_count = hs_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL result_unexpected: got reg=%0d data=%02h, required no pending result", res_reg, res_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({res_reg, res_data} !== exp_e) begin
          errors = errors + 1;
          $display("FAIL result_order: got reg=%0d data=%02h, required reg=%0d data=%02h",
                   res_reg, res_data, exp_e[10:8], exp_e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] rd, input logic [7:0] exp_data, input bit track,
                      output bit acc);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    @(negedge clk);
    acc = in_ready;
    if (acc && track) exp_q.push_back({rd, exp_data});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound, output bit done);
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && fill_count == '0) begin
        done = 1'b1;
        break;
      end
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    checks++;
    if (outs !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit acc;
    int w0;
    res_ready = 1'b1;
    w0 = we_count;
    push(2'b00, 8'hF0, 8'h3C, 3'd5, 8'h30, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b, required 1", acc); end
    @(negedge clk);
    checks++;
    if ({busy, fill_count} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL single_queued: got busy=%b fill=%0d, required busy=0 fill=1", busy, fill_count);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if ({p_write_enable, p_write_reg, p_opcode, p_a, p_b} !== {1'b1, 3'd5, 2'b00, 8'hF0, 8'h3C}) begin
      errors++;
      $display("FAIL single_issue: got we=%b wr=%0d op=%0d a=%02h b=%02h, required we=1 wr=5 op=0 a=F0 b=3C",
               p_write_enable, p_write_reg, p_opcode, p_a, p_b);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if ({p_write_enable, p_read_reg, res_valid} !== {1'b0, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL single_read: got we=%b rr=%0d rv=%b, required we=0 rr=5 rv=0", p_write_enable, p_read_reg, res_valid);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if ({res_valid, res_data, res_reg} !== {1'b1, 8'h30, 3'd5}) begin
      errors++;
      $display("FAIL single_result: got rv=%b data=%02h reg=%0d, required rv=1 data=30 reg=5", res_valid, res_data, res_reg);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if ({res_valid, busy} !== 2'b00 || we_count - w0 != 1) begin
      errors++;
      $display("FAIL single_done: got rv=%b busy=%b pulses=%0d, required rv=0 busy=0 pulses=1", res_valid, busy, we_count - w0);
    end
    tick(1);
  endtask

  task automatic test_readback();
    bit acc;
    bit seen;
    push(2'b01, 8'h00, 8'h01, 3'd5, 8'h01, 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || res_data !== 8'h01 || res_reg !== 3'd5) begin
      errors++;
      $display("FAIL readback_fresh: got seen=%b data=%02h reg=%0d, required seen=1 data=01 reg=5", seen, res_data, res_reg);
    end
    tick(2);
  endtask

  task automatic test_back_to_back();
    bit acc, all_acc, done;
    int h0, n0;
    res_ready = 1'b1;
    h0 = hs_q.size();
    n0 = hs_count;
    all_acc = 1'b1;
    push(2'b01, 8'hA0, 8'h05, 3'd1, 8'hA5, 1'b1, acc); all_acc &= acc;
    push(2'b10, 8'hFF, 8'h0F, 3'd2, 8'hF0, 1'b1, acc); all_acc &= acc;
    push(2'b11, 8'h00, 8'h00, 3'd3, 8'hFF, 1'b1, acc); all_acc &= acc;
    push(2'b00, 8'hFF, 8'hFF, 3'd7, 8'hFF, 1'b1, acc); all_acc &= acc;
    checks++;
    if (all_acc !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b, required 1", all_acc); end
    wait_drain(60, done);
    checks++;
    if (!done || hs_count - n0 != 4) begin
      errors++; $display("FAIL b2b_drain: got done=%b results=%0d, required done=1 results=4", done, hs_count - n0);
    end
    if (hs_q.size() >= h0 + 4) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (hs_q[h0+k+1] - hs_q[h0+k] != 4) begin
          errors++; $display("FAIL b2b_throughput: got gap=%0d, required 4", hs_q[h0+k+1] - hs_q[h0+k]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    bit acc, all_acc;
    int w0, w1;
    res_ready = 1'b0;
    w0 = we_count;
    all_acc = 1'b1;
    push(2'b00, 8'h0F, 8'hFF, 3'd0, 8'h0F, 1'b1, acc); all_acc &= acc;
    push(2'b01, 8'h10, 8'h01, 3'd1, 8'h11, 1'b1, acc); all_acc &= acc;
    push(2'b10, 8'hAA, 8'hFF, 3'd2, 8'h55, 1'b1, acc); all_acc &= acc;
    push(2'b11, 8'h0F, 8'hF0, 3'd3, 8'h00, 1'b1, acc); all_acc &= acc;
    push(2'b01, 8'hC3, 8'h3C, 3'd6, 8'hFF, 1'b1, acc); all_acc &= acc;
    @(negedge clk);
    checks++;
    if (!all_acc || fill_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: got acc=%b fill=%0d in_ready=%b, required acc=1 fill=4 in_ready=0", all_acc, fill_count, in_ready);
    end
    push(2'b00, 8'h12, 8'h34, 3'd7, 8'h10, 1'b1, acc);
    @(negedge clk);
    checks++;
    if (acc !== 1'b0 || fill_count !== 3'd4) begin
      errors++; $display("FAIL stall_refuse: got acc=%b fill=%0d, required acc=0 fill=4", acc, fill_count);
    end
    w1 = we_count;
    tick(6);
    @(negedge clk);
    checks++;
    if ({res_valid, res_data, res_reg} !== {1'b1, 8'h0F, 3'd0}) begin
      errors++;
      $display("FAIL stall_hold: got rv=%b data=%02h reg=%0d, required rv=1 data=0F reg=0", res_valid, res_data, res_reg);
    end
    checks++;
    if (we_count != w1 || w1 - w0 != 1 || fill_count !== 3'd4) begin
      errors++;
      $display("FAIL stall_no_issue: got pulses=%0d extra=%0d fill=%0d, required pulses=1 extra=0 fill=4",
               w1 - w0, we_count - w1, fill_count);
    end
    tick(1);
  endtask

  task automatic test_full_pop();
    bit done;
    int n0;
    n0 = hs_count;
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 2'b00;
    in_a      = 8'h99;
    in_b      = 8'h99;
    in_rd     = 3'd7;
    tick(1);
    @(negedge clk);
    checks++;
    if ({busy, fill_count, in_ready} !== {1'b0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL fullpop_idle: got busy=%b fill=%0d in_ready=%b, required busy=0 fill=4 in_ready=0", busy, fill_count, in_ready);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if ({busy, fill_count} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL fullpop_refuse: got busy=%b fill=%0d, required busy=1 fill=3", busy, fill_count);
    end
    in_valid = 1'b0;
    wait_drain(80, done);
    checks++;
    if (!done || hs_count - n0 != 5) begin
      errors++; $display("FAIL fullpop_drain: got done=%b results=%0d, required done=1 results=5", done, hs_count - n0);
    end
  endtask

  task automatic test_reset_midflight();
    bit acc;
    int n0;
    res_ready = 1'b1;
    n0 = hs_count;
    push(2'b01, 8'h0F, 8'hF0, 3'd4, 8'hFF, 1'b0, acc);
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({p_write_enable, p_write_reg, p_opcode} !== {1'b1, 3'd4, 2'b01}) begin
      errors++;
      $display("FAIL midreset_issue: got we=%b wr=%0d op=%0d, required we=1 wr=4 op=1", p_write_enable, p_write_reg, p_opcode);
    end
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 41'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs: got %h in_ready=%b, required 0 in_ready=1", outs, in_ready);
    end
    tick(6);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || hs_count != n0) begin
      errors++;
      $display("FAIL midreset_dropped: got rv=%b busy=%b results=%0d, required rv=0 busy=0 results=0", res_valid, busy, hs_count - n0);
    end
    tick(1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_b      = '0;
    in_rd     = '0;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_readback();
    test_back_to_back();
    test_full_stall();
    test_full_pop();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
